id_ex_stage: RTL and testbench

- ID/EX pipeline register and operand-selection stage that directly feeds the EX-stage ALU (op1, op2, opcode[4:0], func3, func7).
- Captures decoded instructions from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, stalls ID/IF and inserts a bubble.
- Accepts flush on a taken jump/branch and a global hold from the memory side.

---
 rtl/id_ex_stage.sv | 160 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection and
// ALU operand selection. Operands reach the ALU in the same cycle the instruction enters EX.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_opcode,
    input  logic [2:0]        id_func3,
    input  logic              id_func7,
    input  logic [RIDX_W-1:0] id_rs1,
    input  logic [RIDX_W-1:0] id_rs2,
    input  logic [RIDX_W-1:0] id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              exmem_wen,
    input  logic              exmem_is_load,
    input  logic [RIDX_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_wen,
    input  logic [RIDX_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]   memwb_data,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [4:0]        ex_opcode,
    output logic [2:0]        ex_func3,
    output logic              ex_func7,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [RIDX_W-1:0] ex_rd,
    output logic [XLEN-1:0]   ex_jb_target,
    output logic [XLEN-1:0]   ex_pc,
    output logic              stall_id
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [4:0]        opcode;
        logic [2:0]        func3;
        logic              func7;
        logic [RIDX_W-1:0] rs1;
        logic [RIDX_W-1:0] rs2;
        logic [RIDX_W-1:0] rd;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
    } ex_state_t;

    ex_state_t      st;
    ex_state_t      bubble_s;
    ex_state_t      capture_s;
    logic [XLEN-1:0] f1;
    logic [XLEN-1:0] f2;
    logic [XLEN-1:0] jb_sum;

    // Loads in EX/MEM have no data yet, so they are excluded from forwarding.
    function automatic logic [XLEN-1:0] fwd(
        input logic [RIDX_W-1:0] s,
        input logic [XLEN-1:0]   reg_val,
        input logic              xm_wen,
        input logic              xm_load,
        input logic [RIDX_W-1:0] xm_rd,
        input logic [XLEN-1:0]   xm_res,
        input logic              mw_wen,
        input logic [RIDX_W-1:0] mw_rd,
        input logic [XLEN-1:0]   mw_data
    );
        if (s == '0)
            return '0;
        else if (xm_wen && !xm_load && xm_rd == s)
            return xm_res;
        else if (mw_wen && mw_rd == s)
            return mw_data;
        else
            return reg_val;
    endfunction

    always_comb begin
        f1 = fwd(st.rs1, st.rs1_val, exmem_wen, exmem_is_load, exmem_rd, exmem_result,
                 memwb_wen, memwb_rd, memwb_data);
        f2 = fwd(st.rs2, st.rs2_val, exmem_wen, exmem_is_load, exmem_rd, exmem_result,
                 memwb_wen, memwb_rd, memwb_data);
    end

    assign stall_id = st.valid && st.opcode == OP_LOAD && st.rd != '0
                      && (st.rd == id_rs1 || st.rd == id_rs2)
                      && id_valid && !flush && !hold;

    always_comb begin
        bubble_s        = '0;
        bubble_s.opcode = OP_IMM;
        capture_s = '{valid: 1'b1, pc: id_pc, opcode: id_opcode, func3: id_func3,
                      func7: id_func7, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                      rs1_val: id_rs1_data, rs2_val: id_rs2_data, imm: id_imm};
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            st <= bubble_s;
        end else if (hold) begin
            // Refresh operands so write-backs retiring during the freeze are kept.
            st.rs1_val <= f1;
            st.rs2_val <= f2;
        end else if (stall_id || !id_valid) begin
            st <= bubble_s;
        end else begin
            st <= capture_s;
        end
    end

    always_comb begin
        ex_op1 = '0;
        ex_op2 = '0;
        case (st.opcode)
            OP_REG, OP_BRANCH: begin
                ex_op1 = f1;
                ex_op2 = f2;
            end
            OP_IMM, OP_LOAD, OP_STORE: begin
                ex_op1 = f1;
                ex_op2 = st.imm;
            end
            OP_JALR, OP_JAL, OP_AUIPC: begin
                ex_op1 = st.pc;
                ex_op2 = st.imm;
            end
            OP_LUI: ex_op2 = st.imm;
            default: ;
        endcase
    end

    assign jb_sum       = ((st.opcode == OP_JALR) ? f1 : st.pc) + st.imm;
    assign ex_jb_target = (st.opcode == OP_JALR) ? {jb_sum[XLEN-1:1], 1'b0} : jb_sum;

    assign ex_valid      = st.valid;
    assign ex_opcode     = st.opcode;
    assign ex_func3      = st.func3;
    assign ex_func7      = st.func7;
    assign ex_store_data = f2;
    assign ex_rd         = st.rd;
    assign ex_pc         = st.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: an instruction-level model of what sits in EX, compared every
// cycle, plus hand-computed literal checks on the directed scenarios.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_opcode;
    logic [2:0]  id_func3;
    logic        id_func7;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        exmem_wen, exmem_is_load;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_wen;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic        flush, hold;
    logic        ex_valid;
    logic [4:0]  ex_opcode;
    logic [2:0]  ex_func3;
    logic        ex_func7;
    logic [31:0] ex_op1, ex_op2, ex_store_data;
    logic [4:0]  ex_rd;
    logic [31:0] ex_jb_target, ex_pc;
    logic        stall_id;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.XLEN(32), .RIDX_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode),
        .id_func3(id_func3), .id_func7(id_func7), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .exmem_wen(exmem_wen), .exmem_is_load(exmem_is_load), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_wen(memwb_wen), .memwb_rd(memwb_rd),
        .memwb_data(memwb_data), .flush(flush), .hold(hold), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_func7(ex_func7), .ex_op1(ex_op1),
        .ex_op2(ex_op2), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_jb_target(ex_jb_target), .ex_pc(ex_pc), .stall_id(stall_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the instruction record currently in EX
    typedef struct {
        bit        valid;
        bit [31:0] pc;
        bit [4:0]  op;
        bit [2:0]  f3;
        bit        f7;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] v1, v2, imm;
    } instr_t;

    instr_t m;
    bit     m_live = 0;

    function automatic instr_t nop_instr();
        instr_t n;
        n = '{valid: 0, pc: 0, op: 5'b00100, f3: 0, f7: 0, rs1: 0, rs2: 0, rd: 0,
              v1: 0, v2: 0, imm: 0};
        return n;
    endfunction

    function automatic bit [31:0] m_src(input bit [4:0] s, input bit [31:0] v);
        if (s == 0) return 0;
        if (exmem_wen && !exmem_is_load && exmem_rd == s) return exmem_result;
        if (memwb_wen && memwb_rd == s) return memwb_data;
        return v;
    endfunction

    function automatic bit m_stall(input instr_t c);
        return c.valid && c.op == 5'b00000 && c.rd != 0 &&
               (c.rd == id_rs1 || c.rd == id_rs2) && id_valid && !flush && !hold;
    endfunction

    function automatic instr_t m_next(input instr_t c);
        instr_t n;
        if (flush) return nop_instr();
        if (hold) begin
            n = c;
            n.v1 = m_src(c.rs1, c.v1);
            n.v2 = m_src(c.rs2, c.v2);
            return n;
        end
        if (m_stall(c) || !id_valid) return nop_instr();
        n = '{valid: 1, pc: id_pc, op: id_opcode, f3: id_func3, f7: id_func7, rs1: id_rs1,
              rs2: id_rs2, rd: id_rd, v1: id_rs1_data, v2: id_rs2_data, imm: id_imm};
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m      <= nop_instr();
            m_live <= 1;
        end else if (m_live) begin
            m <= m_next(m);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            bit [31:0] a, b, s1, s2, tgt;
            s1 = m_src(m.rs1, m.v1);
            s2 = m_src(m.rs2, m.v2);
            a = 0; b = 0;
            case (m.op)
                5'b01100, 5'b11000:          begin a = s1;   b = s2;    end
                5'b00100, 5'b00000, 5'b01000: begin a = s1;   b = m.imm; end
                5'b11001, 5'b11011, 5'b00101: begin a = m.pc; b = m.imm; end
                5'b01101:                     begin a = 0;    b = m.imm; end
                default: ;
            endcase
            tgt = (m.op == 5'b11001) ? ((s1 + m.imm) & 32'hFFFF_FFFE) : (m.pc + m.imm);
            check("model_valid",  ex_valid,      m.valid);
            check("model_opcode", ex_opcode,     m.op);
            check("model_func3",  ex_func3,      m.f3);
            check("model_func7",  ex_func7,      m.f7);
            check("model_op1",    ex_op1,        a);
            check("model_op2",    ex_op2,        b);
            check("model_store",  ex_store_data, s2);
            check("model_rd",     ex_rd,         m.rd);
            check("model_jbtgt",  ex_jb_target,  tgt);
            check("model_pc",     ex_pc,         m.pc);
            check("model_stall",  stall_id,      m_stall(m));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_bypass();
        exmem_wen = 0; exmem_is_load = 0; exmem_rd = 0; exmem_result = 0;
        memwb_wen = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm);
        id_valid = 1; id_pc = pc; id_opcode = op; id_func3 = 3'b000; id_func7 = 0;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    endtask

    localparam logic [4:0] OPS [10] = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                                        5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};

    initial begin
        rst = 1; flush = 0; hold = 0;
        clear_bypass();
        issue($urandom, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              $urandom, $urandom, $urandom);

        // Reset
        for (int i = 0; i < 2; i++) begin
            step();
            issue($urandom, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  $urandom, $urandom, $urandom);
            settle();
            check("rst_valid",  ex_valid,  0);
            check("rst_opcode", ex_opcode, 5'b00100);
            check("rst_op1",    ex_op1,    0);
            check("rst_op2",    ex_op2,    0);
            check("rst_stall",  stall_id,  0);
        end
        rst = 0;

        // EX/MEM forwarding wins over MEM/WB
        issue(32'h40, 5'b01100, 1, 2, 3, 5, 7, 0);
        step();
        id_valid = 0;
        exmem_wen = 1; exmem_rd = 1; exmem_result = 32'h10;
        memwb_wen = 1; memwb_rd = 1; memwb_data = 32'h20;
        settle();
        check("fwd_exmem_op1", ex_op1, 32'h10);
        check("fwd_op2_reg",   ex_op2, 7);
        exmem_wen = 0;
        settle();
        check("fwd_memwb_op1", ex_op1, 32'h20);
        memwb_wen = 0;
        settle();
        check("fwd_none_op1",  ex_op1, 5);

        // Load-use
        issue(32'h50, 5'b00000, 1, 0, 5, 32'h100, 0, 0);
        step();
        issue(32'h54, 5'b00100, 5, 0, 6, 0, 0, 1);
        settle();
        check("lu_stall", stall_id, 1);
        step();
        check("lu_bubble", ex_valid, 0);
        check("lu_stall_once", stall_id, 0);
        exmem_wen = 1; exmem_is_load = 1; exmem_rd = 5; exmem_result = 32'h100;
        step();
        id_valid = 0;
        exmem_wen = 1; exmem_is_load = 1; exmem_rd = 5; exmem_result = 32'h999;
        memwb_wen = 1; memwb_rd = 5; memwb_data = 32'h77;
        settle();
        check("lu_valid", ex_valid, 1);
        check("lu_op1",   ex_op1,   32'h77);
        check("lu_op2",   ex_op2,   1);
        clear_bypass();

        // x0 never forwards or stalls
        issue(32'h60, 5'b00100, 0, 0, 7, 32'h1234, 0, 3);
        step();
        id_valid = 0;
        exmem_wen = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
        memwb_wen = 1; memwb_rd = 0; memwb_data = 32'hAB;
        settle();
        check("x0_op1", ex_op1, 0);
        check("x0_op2", ex_op2, 3);
        clear_bypass();
        issue(32'h64, 5'b00000, 1, 0, 0, 0, 0, 0);
        step();
        issue(32'h68, 5'b00100, 0, 0, 2, 0, 0, 9);
        settle();
        check("x0_load_stall", stall_id, 0);
        step();
        id_valid = 0;

        // Flush beats hold; hold freezes but picks up write-backs
        issue(32'h200, 5'b01100, 1, 2, 8, 1, 2, 0);
        step();
        issue(32'h204, 5'b01100, 1, 2, 8, 1, 2, 0);
        flush = 1; hold = 1;
        step();
        flush = 0; hold = 0;
        check("flush_hold_valid", ex_valid, 0);
        issue(32'h300, 5'b01100, 3, 4, 9, 10, 20, 0);
        step();
        issue(32'h304, 5'b00100, 1, 1, 1, 0, 0, 0);
        hold = 1;
        step();
        check("hold1_pc",  ex_pc,  32'h300);
        check("hold1_op2", ex_op2, 20);
        memwb_wen = 1; memwb_rd = 4; memwb_data = 32'h55;
        settle();
        check("hold_wb_op2", ex_op2, 32'h55);
        step();
        memwb_wen = 0;
        settle();
        check("hold2_pc",  ex_pc,  32'h300);
        check("hold2_op2", ex_op2, 32'h55);
        step();
        check("hold3_pc",  ex_pc,  32'h300);
        check("hold3_op2", ex_op2, 32'h55);
        check("hold3_op1", ex_op1, 10);
        hold = 0; id_valid = 0;
        step();
        check("after_hold_bubble", ex_valid, 0);

        // Jump targets and operand classes
        issue(32'h100, 5'b11001, 1, 0, 1, 32'h2001, 0, 4);
        step();
        id_valid = 0;
        settle();
        check("jalr_tgt", ex_jb_target, 32'h2004);
        check("jalr_op1", ex_op1, 32'h100);
        check("jalr_op2", ex_op2, 4);
        issue(32'hFFFF_FFFC, 5'b11011, 0, 0, 1, 0, 0, 8);
        step();
        id_valid = 0;
        settle();
        check("jal_tgt", ex_jb_target, 32'h4);
        check("jal_op1", ex_op1, 32'hFFFF_FFFC);
        issue(32'h80, 5'b01101, 1, 2, 3, 32'h11, 32'h22, 32'h1234_5000);
        step();
        settle();
        check("lui_op1", ex_op1, 0);
        check("lui_op2", ex_op2, 32'h1234_5000);
        issue(32'h84, 5'b11100, 1, 2, 3, 32'h11, 32'h22, 32'h33);
        step();
        settle();
        check("other_op1", ex_op1, 0);
        check("other_op2", ex_op2, 0);
        check("other_store", ex_store_data, 32'h22);

        // Mixed traffic against the model
        for (int i = 0; i < 300; i++) begin
            issue($urandom, OPS[$urandom_range(0, 9)], 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom);
            id_valid      = ($urandom_range(0, 5) != 0);
            exmem_wen     = $urandom_range(0, 1);
            exmem_is_load = ($urandom_range(0, 3) == 0);
            exmem_rd      = 5'($urandom_range(0, 3));
            exmem_result  = $urandom;
            memwb_wen     = $urandom_range(0, 1);
            memwb_rd      = 5'($urandom_range(0, 3));
            memwb_data    = $urandom;
            flush         = ($urandom_range(0, 7) == 0);
            hold          = ($urandom_range(0, 5) == 0);
            step();
        end
        flush = 0; hold = 0; id_valid = 0;
        clear_bypass();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
